// File: rtl/pixel_pkg.sv
// pixel_pkg: shared FSM states, channel codes and write-address field widths for the pixel loader
package pixel_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
   localparam logic [1:0] CH_RED   = 2'b00;
   localparam logic [1:0] CH_GREEN = 2'b01;
   localparam logic [1:0] CH_BLUE  = 2'b10;
   localparam int CH_W  = 2;
   localparam int ROW_W = 5;
   localparam int COL_W = 5;
endpackage

// File: rtl/pixel_addr_cnt.sv
// pixel_addr_cnt: channel-major col/row/ch beat counter; col fastest, then row, then ch
module pixel_addr_cnt
   import pixel_pkg::*;
#(
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int NUM_CH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CH_W-1:0]  ch,
   output logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output logic             last
);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
   localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(NUM_CH - 1);
   logic col_end, row_end, ch_end;
   assign col_end = col == COL_MAX;
   assign row_end = row == ROW_MAX;
   assign ch_end  = ch == CH_MAX;
   assign last    = col_end && row_end && ch_end;
   // advance on each accepted beat; wrapping after the final beat leaves the counter at zero for the next frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
         ch  <= '0;
      end else if (clr) begin
         col <= '0;
         row <= '0;
         ch  <= '0;
      end else if (inc) begin
         col <= col_end ? '0 : col + 1'b1;
         if (col_end) begin
            row <= row_end ? '0 : row + 1'b1;
            if (row_end) ch <= ch_end ? '0 : ch + 1'b1;
         end
      end
   end
endmodule

// File: rtl/pixel_loader.sv
// pixel_loader: streams channel-major samples into pixel memory writes; PIXEL_LOADER_CHECKSUM_EN adds a running sample checksum output
module pixel_loader
   import pixel_pkg::*;
#(
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int NUM_CH = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   output logic        in_ready,
   output logic        write_pixel_signal,
   output logic [15:0] write_pixel_addr,
   output logic [15:0] write_pixel_data,
   output logic        busy,
   output logic        done
`ifdef PIXEL_LOADER_CHECKSUM_EN
   ,output logic [15:0] checksum
`endif
);
   state_t state, next;
   logic [CH_W-1:0]  ch;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic last, acc, clr;
   assign in_ready = (state == LOAD) && !abort;
   assign acc      = in_valid && in_ready;
   assign clr      = ((state == IDLE) && start) || ((state == LOAD) && abort);

   pixel_addr_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_CH(NUM_CH)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (acc),
      .clr (clr),
      .ch  (ch),
      .row (row),
      .col (col),
      .last(last)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   // next state and status outputs; start only matters in IDLE, abort only in LOAD
   always_comb begin
      next = state;
      busy = 1'b0;
      done = 1'b0;
      case (state)
         IDLE:    next = start ? LOAD : IDLE;
         LOAD:    next = abort ? IDLE : (acc && last) ? DONE : LOAD;
         default: next = IDLE;
      endcase
      busy = state == LOAD;
      done = state == DONE;
   end

   // register one write per accepted beat; addr/data hold between writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_pixel_signal <= 1'b0;
         write_pixel_addr   <= '0;
         write_pixel_data   <= '0;
      end else begin
         write_pixel_signal <= acc;
         if (acc) begin
            write_pixel_addr <= {4'b0, ch, row, col};
            write_pixel_data <= in_data;
         end
      end
   end

`ifdef PIXEL_LOADER_CHECKSUM_EN
   // sum at acceptance so the final sample is already included in the done cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      checksum <= '0;
      else if (clr) checksum <= '0;
      else if (acc) checksum <= checksum + in_data;
   end
`endif
endmodule

// File: tb/tb_pixel_loader.sv
// tb_pixel_loader: directed self-checking bench for pixel_loader (32x32x3 frame)
module tb_pixel_loader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready, write_pixel_signal, busy, done;
   logic [15:0] write_pixel_addr, write_pixel_data;
`ifdef PIXEL_LOADER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   pixel_loader dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .abort             (abort),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_ready          (in_ready),
      .write_pixel_signal(write_pixel_signal),
      .write_pixel_addr  (write_pixel_addr),
      .write_pixel_data  (write_pixel_data),
      .busy              (busy),
      .done              (done)
`ifdef PIXEL_LOADER_CHECKSUM_EN
      ,.checksum         (checksum)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int wr_cnt = 0, done_cnt = 0, w0 = 0, d0 = 0, snap = 0;
   logic [15:0] dxor = '0, last_addr = '0;
   bit one_data = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_addr(input int i);
      logic [1:0] c;
      logic [4:0] r, k;
      c = 2'(i / 1024);
      r = 5'((i / 32) % 32);
      k = 5'(i % 32);
      return {4'b0, c, r, k};
   endfunction

   function automatic logic [15:0] exp_data(input int i);
      return one_data ? 16'h0001 : 16'(i) ^ dxor;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic monitor;
      forever begin
         @(negedge clk);
         if (rst) last_addr = '0;
         else begin
            if (write_pixel_signal) begin
               check("wr_addr", write_pixel_addr, exp_addr(wr_cnt - w0));
               check("wr_data", write_pixel_data, exp_data(wr_cnt - w0));
               wr_cnt++;
            end else check("hold_addr", write_pixel_addr, last_addr);
            last_addr = write_pixel_addr;
            if (done) begin
               done_cnt++;
               check("done_with_write", write_pixel_signal, 1);
               check("done_at_last", wr_cnt - w0, 3072);
            end
         end
      end
   endtask

   task automatic pulse_start;
      w0 = wr_cnt;
      d0 = done_cnt;
      start = 1'b1;
      tick;
      start = 1'b0;
      check("busy_after_start", busy, 1);
   endtask

   task automatic send(input int first, input int last, input bit thr);
      int i = first;
      int cyc = 0;
      bit take;
      while (i <= last && cyc < 20000) begin
         in_valid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data = exp_data(i);
         #3 take = in_valid && in_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (take) i++;
      end
      in_valid = 1'b0;
      check("send_progress", i, last + 1);
   endtask

   task automatic frame_end(input string tag);
      tick;
      tick;
      check({tag, "_writes"}, wr_cnt - w0, 3072);
      check({tag, "_dones"}, done_cnt - d0, 1);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      fork
         monitor;
      join_none
      tick;
      tick;
      check("rst_wr", write_pixel_signal, 0);
      check("rst_addr", write_pixel_addr, 0);
      check("rst_data", write_pixel_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", in_ready, 0);
      rst = 1'b0;
      tick;
      // back-to-back full frame, data = beat index
      pulse_start;
      send(0, 3071, 0);
      frame_end("full");
      // throttled frame with distinct data
      dxor = 16'hA5A5;
      pulse_start;
      send(0, 3071, 1);
      frame_end("thr");
      // abort after 100 beats
      dxor = 16'h3C3C;
      pulse_start;
      send(0, 99, 0);
      abort = 1'b1;
      in_valid = 1'b1;
      #3 check("abort_ready", in_ready, 0);
      tick;
      abort = 1'b0;
      in_valid = 1'b0;
      check("abort_idle", busy, 0);
      tick;
      tick;
      check("abort_writes", wr_cnt - w0, 100);
      check("abort_no_done", done_cnt - d0, 0);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      check("abort_in_idle", busy, 0);
      pulse_start;
      send(0, 3071, 0);
      frame_end("after_abort");
      // start ignored in LOAD and DONE
      dxor = 16'h0F0F;
      pulse_start;
      send(0, 49, 0);
      start = 1'b1;
      tick;
      start = 1'b0;
      check("start_in_load", busy, 1);
      send(50, 3071, 0);
      start = 1'b1;
      tick;
      start = 1'b0;
      check("start_in_done", busy, 0);
      tick;
      check("start_frame_writes", wr_cnt - w0, 3072);
      check("start_frame_dones", done_cnt - d0, 1);
      in_valid = 1'b1;
      #3 check("idle_ready", in_ready, 0);
      in_valid = 1'b0;
      tick;
      // reset in the middle of a frame
      dxor = 16'h0000;
      pulse_start;
      send(0, 199, 0);
      in_valid = 1'b1;
      #1 rst = 1'b1;
      #1;
      check("mid_rst_wr", write_pixel_signal, 0);
      check("mid_rst_addr", write_pixel_addr, 0);
      check("mid_rst_data", write_pixel_data, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_ready", in_ready, 0);
      tick;
      rst = 1'b0;
      snap = wr_cnt;
      d0 = done_cnt;
      repeat (5) tick;
      check("post_rst_ready", in_ready, 0);
      check("post_rst_writes", wr_cnt - snap, 0);
      check("post_rst_dones", done_cnt - d0, 0);
      in_valid = 1'b0;
      pulse_start;
      send(0, 3071, 0);
      frame_end("after_rst");
`ifdef PIXEL_LOADER_CHECKSUM_EN
      one_data = 1'b1;
      pulse_start;
      send(0, 3071, 0);
      check("checksum_done", checksum, 16'h0C00);
      frame_end("csum");
      check("checksum_stable", checksum, 16'h0C00);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
